// File: rtl/trace_capture.sv
// trace_capture -- records a DUT output bus into a trace RAM while armed,
// tags every entry with the cycle index it was captured on, then replays the
// trace over a valid/ready port.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   arm          start a new capture (sampled in IDLE only, wins over stop)
//   stop         end capture (sampled in CAPTURE only)
//   sample_en    store sample_data this cycle
//   sample_data  DUT output being traced
//   count        entries stored in current/last capture
//   overflow     sticky: samples dropped because the RAM was full
//   done         one-cycle pulse when the drain completes
//   rd_valid     rd_data/rd_stamp hold a valid entry
//   rd_ready     consumer accepts the entry
//   rd_data      entry data
//   rd_stamp     cycle index at which the entry was captured
//
// Build option: define TRACE_CAPTURE_DELTA_EN to store a sample only when it
// differs from the previously stored one (the first sample is always stored).

module trace_capture #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int STAMP_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               stop,
  input  logic               sample_en,
  input  logic [DATA_W-1:0]  sample_data,
  output logic [ADDR_W:0]    count,
  output logic               overflow,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic [STAMP_W-1:0] rd_stamp
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           wr_ptr;
  // One bit wider than the RAM index so it can reach count==DEPTH.
  logic [ADDR_W:0]             rd_ptr;
  logic [STAMP_W-1:0]          cyc;
  logic [STAMP_W+DATA_W-1:0]   mem [DEPTH];
  logic [STAMP_W+DATA_W-1:0]   rd_entry;
  logic                        full;
  logic                        keep;
  logic                        wr_en;

  // A full RAM is exactly a full-terminated capture: count only reaches
  // DEPTH through the write that also ends the capture.
  assign full = (count == DEPTH_C);

`ifdef TRACE_CAPTURE_DELTA_EN
  logic [DATA_W-1:0] last_data;
  assign keep = (count == '0) || (sample_data != last_data);
`else
  assign keep = 1'b1;
`endif

  assign wr_en    = (state == CAPTURE) && sample_en && !full && keep;
  assign rd_valid = (state == DRAIN) && (rd_ptr != count);
  assign done     = (state == DRAIN) && (rd_ptr == count);

  // Output is forced to zero outside a valid beat so reset leaves it clean
  // even though the RAM itself is never initialised.
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_data  = rd_valid ? rd_entry[DATA_W-1:0] : '0;
  assign rd_stamp = rd_valid ? rd_entry[STAMP_W+DATA_W-1:DATA_W] : '0;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = CAPTURE;
      CAPTURE: if (stop || (wr_en && count == DEPTH_C - 1'b1)) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cyc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef TRACE_CAPTURE_DELTA_EN
      last_data <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arm) begin
            wr_ptr   <= '0;
            count    <= '0;
            cyc      <= '0;
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (cyc != {STAMP_W{1'b1}}) cyc <= cyc + 1'b1;
          if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
`ifdef TRACE_CAPTURE_DELTA_EN
            last_data <= sample_data;
`endif
          end
        end
        DRAIN: begin
          if (rd_valid && rd_ready) rd_ptr <= rd_ptr + 1'b1;
          if (done)                 rd_ptr <= '0;
          // Samples offered after a full-terminated capture are lost.
          if (full && sample_en && keep) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the trace RAM has no reset; its contents are only ever read below
  // count, which reset clears, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= {cyc, sample_data};
  end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture. A phase-level model (idle / capturing
// / draining, with a queue of expected entries) predicts every output and is
// compared against the DUT on each falling edge; directed tests also pin a
// few hand-computed values.

module tb_trace_capture;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int ADDR_W  = 5;
  localparam int STAMP_W = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic                arm, stop, sample_en, rd_ready;
  logic [DATA_W-1:0]   sample_data;
  logic [ADDR_W:0]     count;
  logic                overflow, done, rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [STAMP_W-1:0]  rd_stamp;

  trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STAMP_W(STAMP_W)) dut (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop),
    .sample_en(sample_en), .sample_data(sample_data),
    .count(count), .overflow(overflow), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_stamp(rd_stamp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [DATA_W-1:0]  d;
    logic [STAMP_W-1:0] s;
  } entry_t;

  typedef enum {M_IDLE, M_CAP, M_DRAIN} phase_t;

  phase_t             mph = M_IDLE;
  entry_t             exp_q[$];
  int                 m_count = 0;
  bit                 m_ovf = 1'b0;
  logic [STAMP_W-1:0] m_cyc = '0;
  logic [DATA_W-1:0]  m_last = '0;
  int                 done_cnt = 0;
  int                 xfer_cnt = 0;

  function automatic bit m_keep();
`ifdef TRACE_CAPTURE_DELTA_EN
    return (m_count == 0) || (sample_data != m_last);
`else
    return 1'b1;
`endif
  endfunction

  // Check the outputs produced by the last edge, then advance the model with
  // the inputs that the next edge will sample.
  always @(negedge clock) begin
    if (reset) begin
      mph = M_IDLE; m_count = 0; m_ovf = 1'b0; exp_q.delete();
    end else begin
      check("count",    32'(count),    32'(m_count));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rd_valid", 32'(rd_valid), 32'(mph == M_DRAIN && exp_q.size() > 0));
      check("done",     32'(done),     32'(mph == M_DRAIN && exp_q.size() == 0));
      case (mph)
        M_IDLE: if (arm) begin
          mph = M_CAP; m_count = 0; m_cyc = '0; m_ovf = 1'b0; exp_q.delete();
        end
        M_CAP: begin
          if (sample_en && m_count < DEPTH && m_keep()) begin
            exp_q.push_back('{d: sample_data, s: m_cyc});
            m_count++;
            m_last = sample_data;
          end
          if (m_cyc != '1) m_cyc = m_cyc + 1'b1;
          if (stop || m_count == DEPTH) mph = M_DRAIN;
        end
        M_DRAIN: begin
          if (m_count == DEPTH && sample_en && m_keep()) m_ovf = 1'b1;
          if (exp_q.size() == 0) begin
            mph = M_IDLE;
            done_cnt++;
          end else begin
            check("rd_data",  32'(rd_data),  32'(exp_q[0].d));
            check("rd_stamp", 32'(rd_stamp), 32'(exp_q[0].s));
            if (rd_ready) begin
              void'(exp_q.pop_front());
              xfer_cnt++;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    arm = 0; stop = 0; sample_en = 0; rd_ready = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_arm(input bit with_stop);
    arm = 1; stop = with_stop; sample_en = 0; rd_ready = 0;
    @(posedge clock); #1;
    arm = 0; stop = 0;
  endtask

  task automatic cap(input bit en, input logic [DATA_W-1:0] d, input bit stp);
    sample_en = en; sample_data = d; stop = stp;
    @(posedge clock); #1;
    sample_en = 0; stop = 0;
  endtask

  // Drain with a repeating rd_ready pattern; sample_en held high for the
  // first en_cycles drain cycles. Returns the number of cycles until done.
  task automatic drain(input logic [15:0] pat, input int plen, input int en_cycles,
                       output int cycles);
    int d0 = done_cnt;
    cycles = 0;
    stop = 0;
    for (int i = 0; i < 200; i++) begin
      rd_ready  = pat[i % plen];
      sample_en = (i < en_cycles);
      @(posedge clock); #1;
      cycles++;
      if (done_cnt != d0) break;
    end
    if (done_cnt == d0) check("drain_timeout", 32'd0, 32'd1);
    rd_ready = 0; sample_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ncyc, x0, d0;
    reset = 1; arm = 0; stop = 0; sample_en = 0; rd_ready = 0; sample_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_done",  32'(done), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data",  32'(rd_data), 0);
    check("rst_stamp", 32'(rd_stamp), 0);
    reset = 0;
    idle(2);

    // Test 1: five samples, stop on the fifth; arm+stop together (arm wins).
    do_arm(1'b1);
    for (int i = 0; i < 5; i++) cap(1'b1, 8'h10 + 8'(i), i == 4);
    check("t1_count", 32'(count), 5);
    check("t1_q_first", 32'(exp_q[0]), {8'h10, 16'd0});
    check("t1_q_last",  32'(exp_q[4]), {8'h14, 16'd4});
    d0 = done_cnt; x0 = xfer_cnt;
    drain(16'h1, 1, 0, ncyc);
    check("t1_xfers", 32'(xfer_cnt - x0), 5);
    check("t1_dones", 32'(done_cnt - d0), 1);
    idle(3);

    // Test 2: 40 consecutive samples, no stop -> full, overflow.
    do_arm(1'b0);
    for (int i = 0; i < 32; i++) cap(1'b1, 8'h80 + 8'(i), 1'b0);
    check("t2_count", 32'(count), 32);
    check("t2_q_last", 32'(exp_q[31]), {8'h9F, 16'd31});
    x0 = xfer_cnt;
    drain(16'h1, 1, 8, ncyc);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_xfers", 32'(xfer_cnt - x0), 32);
    idle(2);
    check("t2_ovf_hold", 32'(overflow), 1);

    // Test 3: 4 entries, back-pressure pattern 1,0,0,1,0,1,1.
    do_arm(1'b0);
    for (int i = 0; i < 4; i++) cap(1'b1, 8'hA0 + 8'(i), i == 3);
    x0 = xfer_cnt;
    drain(16'b1101001, 7, 0, ncyc);
    check("t3_xfers", 32'(xfer_cnt - x0), 4);
    check("t3_drain_cycles", 32'(ncyc), 8);
    idle(2);

    // Test 4: empty capture.
    do_arm(1'b0);
    cap(1'b0, 8'h00, 1'b1);
    check("t4_count", 32'(count), 0);
    d0 = done_cnt;
    drain(16'h1, 1, 0, ncyc);
    check("t4_drain_cycles", 32'(ncyc), 1);
    check("t4_dones", 32'(done_cnt - d0), 1);
    idle(2);

    // Test 5: reset mid-capture, then a fresh 2-entry capture.
    do_arm(1'b0);
    for (int i = 0; i < 3; i++) cap(1'b1, 8'h30 + 8'(i), 1'b0);
    #2 reset = 1;
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_valid", 32'(rd_valid), 0);
    check("t5_done",  32'(done), 0);
    check("t5_ovf",   32'(overflow), 0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 0;
    idle(1);
    do_arm(1'b0);
    cap(1'b1, 8'h55, 1'b0);
    cap(1'b1, 8'h66, 1'b1);
    check("t5_q0", 32'(exp_q[0]), {8'h55, 16'd0});
    check("t5_q1", 32'(exp_q[1]), {8'h66, 16'd1});
    x0 = xfer_cnt;
    drain(16'h1, 1, 0, ncyc);
    check("t5_xfers", 32'(xfer_cnt - x0), 2);
    idle(2);

`ifdef TRACE_CAPTURE_DELTA_EN
    // Test 6: only changes are stored.
    begin
      logic [DATA_W-1:0] vals [6] = '{8'd3, 8'd3, 8'd3, 8'd7, 8'd7, 8'd3};
      do_arm(1'b0);
      for (int i = 0; i < 6; i++) cap(1'b1, vals[i], i == 5);
      check("t6_count", 32'(count), 3);
      check("t6_q0", 32'(exp_q[0]), {8'd3, 16'd0});
      check("t6_q1", 32'(exp_q[1]), {8'd7, 16'd3});
      check("t6_q2", 32'(exp_q[2]), {8'd3, 16'd5});
      drain(16'h1, 1, 0, ncyc);
      check("t6_ovf", 32'(overflow), 0);
      idle(2);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
